// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider.
// Produces one quotient bit per clock. Quotient, remainder and the
// divide-by-zero flag are registered and come with a one-cycle done strobe.
module seq_divider #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] q_q;     // shifting dividend / partial quotient
   logic [WIDTH-1:0] d_q;     // latched divisor
   // The partial remainder always stays below the divisor, so its extra
   // (WIDTH+1)th bit is always zero; only WIDTH bits are stored.
   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic             dbz_q;

   logic [WIDTH:0]   s_w;
   logic [WIDTH:0]   t_w;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] r_d;

   // One restoring trial-subtraction step on the current partial remainder.
   always_comb begin
      s_w = {r_q, q_q[WIDTH-1]};
      t_w = s_w - {1'b0, d_q};
      if (!t_w[WIDTH]) begin
         r_d = t_w[WIDTH-1:0];
         q_d = {q_q[WIDTH-2:0], 1'b1};
      end else begin
         r_d = s_w[WIDTH-1:0];
         q_d = {q_q[WIDTH-2:0], 1'b0};
      end
   end

   // Control FSM with registered status and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         d_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  if (divisor == '0) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     quo_q   <= '1;
                     rem_q   <= dividend;
                     dbz_q   <= 1'b1;
                  end else begin
                     state_q <= CALC;
                     busy_q  <= 1'b1;
                     q_q     <= dividend;
                     d_q     <= divisor;
                     r_q     <= '0;
                     cnt_q   <= CW'(WIDTH);
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            CALC: begin
               q_q   <= q_d;
               r_q   <= r_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  quo_q   <= q_d;
                  rem_q   <= r_d;
                  dbz_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (WIDTH = 8).
`timescale 1ns/1ps
module tb_seq_divider;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int n_cmp = 0;
   int n_err = 0;

   seq_divider #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end

   // Drive a request across the sampling edge; returns 1ns into cycle 1.
   task automatic issue(input logic [7:0] a, input logic [7:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      step(); step();
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
      n_cmp++; if (quotient !== 8'd0) begin n_err++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
      n_cmp++; if (remainder !== 8'd0) begin n_err++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
      start = 1'b0; rst = 1'b0;
      step();
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_start_ignored: got %b expected 00", {busy, done}); end
   endtask

   task automatic test_normal();
      int va[4] = '{200, 255, 5, 0};
      int vb[4] = '{7, 1, 9, 3};
      int eq[4] = '{28, 255, 0, 0};
      int er[4] = '{4, 0, 5, 0};
      for (int i = 0; i < 4; i++) begin
         issue(8'(va[i]), 8'(vb[i]));
         for (int c = 1; c <= 9; c++) begin
            if (c < 9) begin
               n_cmp++;
               if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL normal_busy[%0d] cycle %0d: got %b expected 10", i, c, {busy, done}); end
               step();
            end else begin
               n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL normal_done[%0d]: got %b expected 01", i, {busy, done}); end
               n_cmp++; if (quotient !== 8'(eq[i])) begin n_err++; $display("FAIL normal_quot[%0d]: got %0d expected %0d", i, quotient, eq[i]); end
               n_cmp++; if (remainder !== 8'(er[i])) begin n_err++; $display("FAIL normal_rem[%0d]: got %0d expected %0d", i, remainder, er[i]); end
               n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL normal_dbz[%0d]: got %b expected 0", i, div_by_zero); end
            end
         end
         step();
         n_cmp++;
         if (done !== 1'b0 || quotient !== 8'(eq[i]) || remainder !== 8'(er[i])) begin
            n_err++; $display("FAIL normal_hold[%0d]: got done=%b q=%0d r=%0d expected done=0 q=%0d r=%0d", i, done, quotient, remainder, eq[i], er[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      issue(8'd77, 8'd0);
      n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL dz_done: got %b expected 01", {busy, done}); end
      n_cmp++; if (quotient !== 8'd255) begin n_err++; $display("FAIL dz_quot: got %0d expected 255", quotient); end
      n_cmp++; if (remainder !== 8'd77) begin n_err++; $display("FAIL dz_rem: got %0d expected 77", remainder); end
      n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b expected 1", div_by_zero); end
      step();
      n_cmp++; if ({busy, done, div_by_zero} !== 3'b001) begin n_err++; $display("FAIL dz_after: got %b expected 001", {busy, done, div_by_zero}); end
      issue(8'd10, 8'd3);
      n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_hold_during_calc: got %b expected 1", div_by_zero); end
      for (int c = 1; c < 9; c++) step();
      n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL dz_next_done: got %b expected 01", {busy, done}); end
      n_cmp++; if (quotient !== 8'd3) begin n_err++; $display("FAIL dz_next_quot: got %0d expected 3", quotient); end
      n_cmp++; if (remainder !== 8'd1) begin n_err++; $display("FAIL dz_next_rem: got %0d expected 1", remainder); end
      n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_next_flag: got %b expected 0", div_by_zero); end
      step();
   endtask

   task automatic test_start_busy();
      int dones = 0;
      issue(8'd100, 8'd10);
      for (int c = 1; c <= 12; c++) begin
         if (done === 1'b1) dones++;
         if (c == 9) begin
            n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL sb_done: got %b expected 01", {busy, done}); end
            n_cmp++; if (quotient !== 8'd10) begin n_err++; $display("FAIL sb_quot: got %0d expected 10", quotient); end
            n_cmp++; if (remainder !== 8'd0) begin n_err++; $display("FAIL sb_rem: got %0d expected 0", remainder); end
         end
         if (c == 4) begin
            start = 1'b1; dividend = 8'd9; divisor = 8'd2;
         end else begin
            start = 1'b0;
         end
         step();
      end
      n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL sb_done_count: got %0d expected 1", dones); end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      issue(8'd250, 8'd3);
      for (int c = 1; c < 5; c++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if ({busy, done, div_by_zero} !== 3'b000) begin n_err++; $display("FAIL rm_flags: got %b expected 000", {busy, done, div_by_zero}); end
      n_cmp++; if (quotient !== 8'd0 || remainder !== 8'd0) begin n_err++; $display("FAIL rm_results: got q=%0d r=%0d expected q=0 r=0", quotient, remainder); end
      for (int c = 0; c < 10; c++) begin
         if (done === 1'b1 || busy === 1'b1) dones++;
         step();
      end
      n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL rm_no_activity: got %0d expected 0", dones); end
      issue(8'd250, 8'd3);
      for (int c = 1; c < 9; c++) step();
      n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL rm_done: got %b expected 01", {busy, done}); end
      n_cmp++; if (quotient !== 8'd83) begin n_err++; $display("FAIL rm_quot: got %0d expected 83", quotient); end
      n_cmp++; if (remainder !== 8'd1) begin n_err++; $display("FAIL rm_rem: got %0d expected 1", remainder); end
      step();
   endtask

   task automatic test_back_to_back();
      // Operands accepted at edges 0, 9, 18: 11/1, 88/10, 165/6.
      int eq[3] = '{11, 8, 27};
      int er[3] = '{0, 8, 3};
      int dones = 0;
      for (int c = 0; c < 27; c++) begin
         start    = 1'b1;
         dividend = 8'((c * 37 + 11) % 256);
         divisor  = 8'((c % 13) + 1);
         step();
         if ((c + 1) % 9 == 0) begin
            n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL b2b_done cycle %0d: got %b expected 01", c + 1, {busy, done}); end
            n_cmp++;
            if (quotient !== 8'(eq[dones]) || remainder !== 8'(er[dones])) begin
               n_err++; $display("FAIL b2b_result[%0d]: got q=%0d r=%0d expected q=%0d r=%0d", dones, quotient, remainder, eq[dones], er[dones]);
            end
            dones++;
         end else begin
            n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL b2b_busy cycle %0d: got %b expected 10", c + 1, {busy, done}); end
         end
      end
      start = 1'b0;
      step();
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL b2b_idle: got %b expected 00", {busy, done}); end
   endtask

   task automatic test_random();
      int a, b, w;
      for (int i = 0; i < 1000; i++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(1, 255));
         issue(8'(a), 8'(b));
         w = 1;
         while (done !== 1'b1 && w < 20) begin
            step();
            w++;
         end
         n_cmp++;
         if (done !== 1'b1) begin
            n_err++; $display("FAIL rand_timeout[%0d]: got no done expected done within 20 cycles", i);
         end else if (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b || w != 9) begin
            n_err++; $display("FAIL rand_invariant[%0d] %0d/%0d: got q=%0d r=%0d latency=%0d expected q=%0d r=%0d latency=9", i, a, b, quotient, remainder, w, a / b, a % b);
         end
         step();
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      @(posedge clk); #1;
      test_reset();
      test_normal();
      test_div_zero();
      test_start_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
